// File: rtl/int_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : int_issue_queue
//  Description : Collapsing, age-ordered integer reservation station. Holds
//                dispatched integer/branch ops until both operands are valid,
//                snoops the CDB for operand wakeup, and presents the oldest
//                ready entry to the integer execute stage each cycle.
//                Entry 0 is always the oldest.
//  Parameters  : DEPTH (2..8), TAG_W, DATA_W
//  Ports       : clk, rst (async, active high)
//                disp_*            dispatch request and operand fields
//                iq_full           no free entry (dispatch ignored)
//                cdb_valid/tag/result  result broadcast for wakeup
//                exec_en           execute stage can accept this cycle
//                issue_queue_rdy   issued op valid this cycle
//                iss_*             issued op fields (zero when not issuing)
//                iq_count          occupied entries
//  Options     : INT_IQ_FLUSH_EN adds a `flush` input that empties the queue.
//  Revision    : 1.0  initial release
// ============================================================================
module int_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef INT_IQ_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         disp_valid,
    input  logic [6:0]                   disp_opcode,
    input  logic [2:0]                   disp_func3,
    input  logic [6:0]                   disp_func7,
    input  logic [TAG_W-1:0]             disp_rd_tag,
    input  logic                         disp_rs1_valid,
    input  logic [TAG_W-1:0]             disp_rs1_tag,
    input  logic [DATA_W-1:0]            disp_rs1_data,
    input  logic                         disp_rs2_valid,
    input  logic [TAG_W-1:0]             disp_rs2_tag,
    input  logic [DATA_W-1:0]            disp_rs2_data,
    output logic                         iq_full,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_result,
    input  logic                         exec_en,
    output logic                         issue_queue_rdy,
    output logic [6:0]                   iss_opcode,
    output logic [2:0]                   iss_func3,
    output logic [6:0]                   iss_func7,
    output logic [TAG_W-1:0]             iss_rd_tag,
    output logic [DATA_W-1:0]            iss_rs1_data,
    output logic [DATA_W-1:0]            iss_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0]   iq_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [TAG_W-1:0]  rd_tag;
        logic              rs1_valid;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs2_valid;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
    } entry_t;

    entry_t             r_q     [DEPTH];
    logic [CNT_W-1:0]   r_count;

    entry_t             w_ext   [DEPTH+1];  // r_q plus an empty slot so the top entry can shift in zero
    entry_t             w_q_nxt [DEPTH];
    entry_t             w_disp_entry;
    entry_t             w_sel_entry;
    logic [DEPTH-1:0]   w_ready;
    logic               w_any_ready;
    logic [IDX_W-1:0]   w_sel;
    logic               w_issue;
    logic               w_accept;
    logic               w_flush;
    logic [CNT_W-1:0]   w_disp_idx;
    logic [CNT_W-1:0]   w_count_nxt;

`ifdef INT_IQ_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Operand not yet valid and its producer is broadcasting right now.
    function automatic logic cdb_hit(input logic v, input logic [TAG_W-1:0] tag,
                                     input logic cv, input logic [TAG_W-1:0] ctag);
        return !v && cv && (tag == ctag);
    endfunction

    // Readiness is taken from registered state only, so a wakeup edge
    // makes the entry eligible in the following cycle.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_ready
            assign w_ready[g] = r_q[g].valid & r_q[g].rs1_valid & r_q[g].rs2_valid;
            assign w_ext[g]   = r_q[g];
        end
    endgenerate
    assign w_ext[DEPTH] = '0;

    // Lowest index ready entry is the oldest ready one.
    always_comb begin
        w_any_ready = 1'b0;
        w_sel       = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_any_ready = 1'b1;
                w_sel       = IDX_W'(i);
            end
        end
    end

    assign w_issue         = exec_en & w_any_ready & ~w_flush;
    assign issue_queue_rdy = w_issue;
    assign w_sel_entry     = r_q[w_sel];

    assign iss_opcode   = w_issue ? w_sel_entry.opcode   : '0;
    assign iss_func3    = w_issue ? w_sel_entry.func3    : '0;
    assign iss_func7    = w_issue ? w_sel_entry.func7    : '0;
    assign iss_rd_tag   = w_issue ? w_sel_entry.rd_tag   : '0;
    assign iss_rs1_data = w_issue ? w_sel_entry.rs1_data : '0;
    assign iss_rs2_data = w_issue ? w_sel_entry.rs2_data : '0;

    // Full is judged on the registered count, so a full queue rejects
    // dispatch even in a cycle where it also issues.
    assign iq_full    = (r_count == c_depth);
    assign iq_count   = r_count;
    assign w_accept   = disp_valid & ~iq_full;
    assign w_disp_idx = r_count - (w_issue ? CNT_W'(1) : CNT_W'(0));

    always_comb begin
        w_count_nxt = r_count;
        if (w_issue && !w_accept) begin
            w_count_nxt = r_count - CNT_W'(1);
        end else if (!w_issue && w_accept) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Incoming op, with same-cycle CDB bypass on unready operands.
    always_comb begin
        w_disp_entry           = '0;
        w_disp_entry.valid     = 1'b1;
        w_disp_entry.opcode    = disp_opcode;
        w_disp_entry.func3     = disp_func3;
        w_disp_entry.func7     = disp_func7;
        w_disp_entry.rd_tag    = disp_rd_tag;
        w_disp_entry.rs1_valid = disp_rs1_valid;
        w_disp_entry.rs1_tag   = disp_rs1_tag;
        w_disp_entry.rs1_data  = disp_rs1_data;
        w_disp_entry.rs2_valid = disp_rs2_valid;
        w_disp_entry.rs2_tag   = disp_rs2_tag;
        w_disp_entry.rs2_data  = disp_rs2_data;
        if (cdb_hit(disp_rs1_valid, disp_rs1_tag, cdb_valid, cdb_tag)) begin
            w_disp_entry.rs1_valid = 1'b1;
            w_disp_entry.rs1_data  = cdb_result;
        end
        if (cdb_hit(disp_rs2_valid, disp_rs2_tag, cdb_valid, cdb_tag)) begin
            w_disp_entry.rs2_valid = 1'b1;
            w_disp_entry.rs2_data  = cdb_result;
        end
    end

    // Next state: collapse above the issued slot, then wake, then dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && (IDX_W'(i) >= w_sel)) begin
                w_q_nxt[i] = w_ext[i+1];
            end else begin
                w_q_nxt[i] = w_ext[i];
            end
            if (w_q_nxt[i].valid) begin
                if (cdb_hit(w_q_nxt[i].rs1_valid, w_q_nxt[i].rs1_tag, cdb_valid, cdb_tag)) begin
                    w_q_nxt[i].rs1_valid = 1'b1;
                    w_q_nxt[i].rs1_data  = cdb_result;
                end
                if (cdb_hit(w_q_nxt[i].rs2_valid, w_q_nxt[i].rs2_tag, cdb_valid, cdb_tag)) begin
                    w_q_nxt[i].rs2_valid = 1'b1;
                    w_q_nxt[i].rs2_data  = cdb_result;
                end
            end
            if (w_accept && (CNT_W'(i) == w_disp_idx)) begin
                w_q_nxt[i] = w_disp_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else if (w_flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i].valid <= 1'b0;
            end
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_q_nxt[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_issue_queue
//  Description : Self-checking bench for int_issue_queue. Directed scenarios
//                followed by random traffic, all compared against a
//                queue-based reference model of the reservation station.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_issue_queue;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_l = 1'b0;
    logic              disp_valid = 1'b0;
    logic [6:0]        disp_opcode = '0;
    logic [2:0]        disp_func3 = '0;
    logic [6:0]        disp_func7 = '0;
    logic [TAG_W-1:0]  disp_rd_tag = '0;
    logic              disp_rs1_valid = 1'b0;
    logic [TAG_W-1:0]  disp_rs1_tag = '0;
    logic [DATA_W-1:0] disp_rs1_data = '0;
    logic              disp_rs2_valid = 1'b0;
    logic [TAG_W-1:0]  disp_rs2_tag = '0;
    logic [DATA_W-1:0] disp_rs2_data = '0;
    logic              iq_full;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_result = '0;
    logic              exec_en = 1'b0;
    logic              issue_queue_rdy;
    logic [6:0]        iss_opcode;
    logic [2:0]        iss_func3;
    logic [6:0]        iss_func7;
    logic [TAG_W-1:0]  iss_rd_tag;
    logic [DATA_W-1:0] iss_rs1_data;
    logic [DATA_W-1:0] iss_rs2_data;
    logic [2:0]        iq_count;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct {
        logic [6:0]        op;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [TAG_W-1:0]  rd;
        bit                v1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] d1;
        bit                v2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] d2;
    } ment_t;

    ment_t q[$];   // reference model, oldest first

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst(rst),
`ifdef INT_IQ_FLUSH_EN
        .flush(flush_l),
`endif
        .disp_valid(disp_valid),
        .disp_opcode(disp_opcode),
        .disp_func3(disp_func3),
        .disp_func7(disp_func7),
        .disp_rd_tag(disp_rd_tag),
        .disp_rs1_valid(disp_rs1_valid),
        .disp_rs1_tag(disp_rs1_tag),
        .disp_rs1_data(disp_rs1_data),
        .disp_rs2_valid(disp_rs2_valid),
        .disp_rs2_tag(disp_rs2_tag),
        .disp_rs2_data(disp_rs2_data),
        .iq_full(iq_full),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_result(cdb_result),
        .exec_en(exec_en),
        .issue_queue_rdy(issue_queue_rdy),
        .iss_opcode(iss_opcode),
        .iss_func3(iss_func3),
        .iss_func7(iss_func7),
        .iss_rd_tag(iss_rd_tag),
        .iss_rs1_data(iss_rs1_data),
        .iss_rs2_data(iss_rs2_data),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_ready();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].v1 && q[i].v2) return i;
        end
        return -1;
    endfunction

    // One clock: check outputs against the model, take the edge, advance model.
    task automatic cycle();
        int           sel;
        logic         exp_rdy;
        logic [86:0]  exp_iss;
        bit           full_before;
        ment_t        e;
        #1;
        sel     = find_ready();
        exp_rdy = exec_en && (sel >= 0) && !flush_l;
        exp_iss = '0;
        if (exp_rdy) exp_iss = {q[sel].op, q[sel].f3, q[sel].f7, q[sel].rd, q[sel].d1, q[sel].d2};
        check("rdy", issue_queue_rdy, exp_rdy);
        check("iss", {iss_opcode, iss_func3, iss_func7, iss_rd_tag, iss_rs1_data, iss_rs2_data}, exp_iss);
        check("count", iq_count, q.size());
        check("full", iq_full, q.size() == DEPTH);
        full_before = (q.size() == DEPTH);
        @(posedge clk);
        if (flush_l) begin
            q.delete();
        end else begin
            if (exp_rdy) q.delete(sel);
            foreach (q[k]) begin
                if (!q[k].v1 && cdb_valid && q[k].t1 == cdb_tag) begin q[k].v1 = 1; q[k].d1 = cdb_result; end
                if (!q[k].v2 && cdb_valid && q[k].t2 == cdb_tag) begin q[k].v2 = 1; q[k].d2 = cdb_result; end
            end
            if (disp_valid && !full_before) begin
                e = '{disp_opcode, disp_func3, disp_func7, disp_rd_tag, disp_rs1_valid, disp_rs1_tag,
                      disp_rs1_data, disp_rs2_valid, disp_rs2_tag, disp_rs2_data};
                if (!e.v1 && cdb_valid && e.t1 == cdb_tag) begin e.v1 = 1; e.d1 = cdb_result; end
                if (!e.v2 && cdb_valid && e.t2 == cdb_tag) begin e.v2 = 1; e.d2 = cdb_result; end
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic disp(input logic [TAG_W-1:0] rd, input logic v1, input logic [TAG_W-1:0] t1,
                        input logic [DATA_W-1:0] d1, input logic v2, input logic [TAG_W-1:0] t2,
                        input logic [DATA_W-1:0] d2);
        disp_valid = 1'b1; disp_opcode = 7'h33; disp_func3 = 3'd0; disp_func7 = 7'd0;
        disp_rd_tag = rd;
        disp_rs1_valid = v1; disp_rs1_tag = t1; disp_rs1_data = d1;
        disp_rs2_valid = v2; disp_rs2_tag = t2; disp_rs2_data = d2;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        exec_en = 1'b1;
        rst = 1'b1;
        q.delete();
        #1;
        check("reset_rdy", issue_queue_rdy, 1'b0);
        check("reset_count", iq_count, 0);
        check("reset_full", iq_full, 1'b0);
        check("reset_iss", {iss_opcode, iss_rd_tag, iss_rs1_data, iss_rs2_data}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // ADD: both operands valid issues the cycle after dispatch
        do_reset();
        disp(6'd1, 1, 0, 32'd5, 1, 0, 32'd7);
        cycle();
        idle();
        check("add_rdy", issue_queue_rdy, 1'b1);
        check("add_rs1", iss_rs1_data, 32'd5);
        check("add_rs2", iss_rs2_data, 32'd7);
        check("add_cnt1", iq_count, 1);
        cycle();
        check("add_cnt0", iq_count, 0);

        // Wakeup from CDB
        disp(6'd2, 0, 6'd3, 32'd0, 1, 0, 32'd1);
        cycle();
        idle();
        check("wake_wait", issue_queue_rdy, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_result = 32'h10;
        cycle();
        idle();
        check("wake_rdy", issue_queue_rdy, 1'b1);
        check("wake_rs1", iss_rs1_data, 32'h10);
        cycle();

        // Dispatch / CDB bypass
        disp(6'd4, 0, 6'd9, 32'd0, 1, 0, 32'd2);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_result = 32'hAA;
        cycle();
        idle();
        check("byp_rdy", issue_queue_rdy, 1'b1);
        check("byp_rs1", iss_rs1_data, 32'hAA);
        cycle();

        // Age order: A waits tag1, B ready, C waits tag2, D ready
        do_reset();
        exec_en = 1'b0;
        disp(6'd10, 0, 6'd1, 32'd0, 1, 0, 32'd2);    cycle();
        disp(6'd11, 1, 0, 32'd3, 1, 0, 32'd4);       cycle();
        disp(6'd12, 1, 0, 32'd5, 0, 6'd2, 32'd0);    cycle();
        disp(6'd13, 1, 0, 32'd6, 1, 0, 32'd7);       cycle();
        check("age_full", iq_full, 1'b1);
        disp(6'd14, 1, 0, 32'd8, 1, 0, 32'd9);       cycle();
        check("age_drop_cnt", iq_count, 4);
        idle();
        exec_en = 1'b1;
        #1;
        check("age_first_B", iss_rd_tag, 6'd11);
        cycle();
        check("age_second_D", iss_rd_tag, 6'd13);
        cycle();
        check("age_none", issue_queue_rdy, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_result = 32'h55;
        cycle();
        idle();
        check("age_third_A", iss_rd_tag, 6'd10);
        check("age_A_rs1", iss_rs1_data, 32'h55);
        cycle();
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_result = 32'h66;
        cycle();
        idle();
        check("age_fourth_C", iss_rd_tag, 6'd12);
        cycle();
        check("age_empty", iq_count, 0);

        // Full queue rejects dispatch even while issuing
        do_reset();
        exec_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(TAG_W'(20 + i), 1, 0, 32'(i), 1, 0, 32'(i + 1));
            cycle();
        end
        exec_en = 1'b1;
        disp(6'd30, 1, 0, 32'd1, 1, 0, 32'd1);
        cycle();
        idle();
        check("full_issue_cnt", iq_count, DEPTH - 1);

        // Reset in the middle of operation
        do_reset();
        exec_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(TAG_W'(40 + i), 1, 0, 32'(i), 1, 0, 32'(i));
            cycle();
        end
        idle();
        exec_en = 1'b1;
        #1;
        check("mid_rdy_before", issue_queue_rdy, 1'b1);
        do_reset();

`ifdef INT_IQ_FLUSH_EN
        exec_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(TAG_W'(50 + i), 1, 0, 32'(i), 1, 0, 32'(i));
            cycle();
        end
        idle();
        exec_en = 1'b1;
        flush_l = 1'b1;
        cycle();
        flush_l = 1'b0;
        check("flush_cnt", iq_count, 0);
        check("flush_rdy", issue_queue_rdy, 1'b0);
`endif

        // Random traffic against the reference model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            disp_valid     = ($urandom_range(0, 2) != 0);
            disp_opcode    = 7'($urandom);
            disp_func3     = 3'($urandom);
            disp_func7     = 7'($urandom);
            disp_rd_tag    = TAG_W'($urandom);
            disp_rs1_valid = ($urandom_range(0, 2) == 0);
            disp_rs1_tag   = TAG_W'($urandom_range(0, 7));
            disp_rs1_data  = $urandom;
            disp_rs2_valid = ($urandom_range(0, 2) != 0);
            disp_rs2_tag   = TAG_W'($urandom_range(0, 7));
            disp_rs2_data  = $urandom;
            cdb_valid      = ($urandom_range(0, 1) == 1);
            cdb_tag        = TAG_W'($urandom_range(0, 7));
            cdb_result     = $urandom;
            exec_en        = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
